// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial add/subtract unit.
// Holds the FSM state type, default operand/digit sizing and a clog2 helper
// used to size the digit counter.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIGIT = 8;

  // Ceiling log2 for elaboration-time sizing; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder built from full-adder bit cells.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller registers the results.
// Ports: a, b (digit operands), cin (carry in), sum (digit result),
//        cout (carry out of the top bit), c_msb_in (carry into the top bit,
//        used by the caller for signed overflow detection).
module digit_adder #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  // c[i] is the carry into bit i; c[DIGIT] leaves the digit.
  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract, DIGIT bits per cycle, LS digit first.
// Latency: acceptance edge to out_valid is NDIG edges; one op per NDIG+2 cycles.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with a, b, cin, sub
//        (sub=1 computes a-b, cin ignored); out_valid/out_ready with sum, cout
//        (carry out of MSB; in subtract mode 1 means no borrow), ovf (signed).
// Optional build macro DIGIT_SERIAL_ADDER_SAT_EN: on signed overflow, sum is
// replaced by the saturation value chosen from the sign of operand a.
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (clog2(NDIG) < 1) ? 1 : clog2(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] dig_ext;
  logic             carry;
  logic             cout_r;
  logic             ovf_r;
  logic             accept;
  logic             last_dig;
  logic [DIGIT-1:0] d_sum;
  logic             d_cout;
  logic             d_cmsb;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a        (a_sh[DIGIT-1:0]),
    .b        (b_sh[DIGIT-1:0]),
    .cin      (carry),
    .sum      (d_sum),
    .cout     (d_cout),
    .c_msb_in (d_cmsb)
  );

  assign accept   = in_valid && in_ready;
  assign last_dig = (cnt == LAST);

  // Result digit enters at the MSB end so after NDIG shifts the first digit
  // computed sits at bit 0.
  assign dig_ext = WIDTH'(d_sum) << (WIDTH - DIGIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_dig) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      // Subtract is a + ~b + 1, so the inversion and the forced carry-in are
      // applied once here and the digit loop is identical for both modes.
      cnt    <= '0;
      a_sh   <= a;
      b_sh   <= sub ? ~b : b;
      carry  <= sub ? 1'b1 : cin;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      sum_r <= (sum_r >> DIGIT) | dig_ext;
      carry <= d_cout;
      cnt   <= cnt + 1'b1;
      if (last_dig) begin
        cout_r <= d_cout;
        ovf_r  <= d_cmsb ^ d_cout;
      end
    end
  end

`ifdef DIGIT_SERIAL_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Sign of a is shifted out during RUN, so keep a copy for the clamp.
  logic a_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      a_msb <= 1'b0;
    else if (accept) a_msb <= a[WIDTH-1];
  end

  assign sum = ovf_r ? (a_msb ? SAT_NEG : SAT_POS) : sum_r;
`else
  assign sum = sum_r;
`endif

  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_digit_serial_adder.sv
`timescale 1ns/1ps
module tb_digit_serial_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks      = 0;
  int errors      = 0;
  bit sweep_go    = 1'b0;
  int sweep_done  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the w-bit operands.
  // Returns {ovf, cout, sum[63:0]}.
  function automatic logic [65:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic ci, input logic sb);
    logic [63:0] mask, aa, bb, full, s;
    logic        co, ov, sa;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'h0, a} & mask;
    bb   = sb ? (~{32'h0, b}) & mask : {32'h0, b} & mask;
    full = aa + bb + (sb ? 64'd1 : {63'd0, ci});
    s    = full & mask;
    co   = full[w];
    sa   = aa[w-1];
    ov   = (sa == bb[w-1]) && (s[w-1] != sa);
`ifdef DIGIT_SERIAL_ADDER_SAT_EN
    if (ov) s = sa ? (64'd1 << (w-1)) : (mask >> 1);
`endif
    return {ov, co, s};
  endfunction

  // cfg[0]: 32/8 (directed + random), cfg[1]: 32/1, cfg[2]: 16/16.
  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int W = (g == 2) ? 16 : 32;
    localparam int D = (g == 0) ? 8 : (g == 1) ? 1 : 16;

    logic         iv, ir, ci, sb, ov, orr, co, of;
    logic [W-1:0] a, b, s;
    logic [65:0]  q[$];
    int           delivered = 0;

    digit_serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
      .cin(ci), .sub(sb), .out_valid(ov), .out_ready(orr), .sum(s), .cout(co), .ovf(of)
    );

    // Scoreboard: push the expected result at acceptance, retire at output handshake.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) q.delete();
      else begin
        if (iv && ir) q.push_back(model(W, 32'(a), 32'(b), ci, sb));
        if (ov && orr && q.size() > 0) begin
          void'(q.pop_front());
          delivered++;
        end
      end
    end

    // Compare every cycle the result is presented.
    always @(negedge clk) begin
      if (rst_n && ov) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cfg%0d spurious out_valid: got sum %0h with no pending operation", g, s);
        end else begin
          chk($sformatf("cfg%0d sum", g), 64'(s), q[0][63:0]);
          chk($sformatf("cfg%0d cout", g), {63'd0, co}, {63'd0, q[0][64]});
          chk($sformatf("cfg%0d ovf", g), {63'd0, of}, {63'd0, q[0][65]});
        end
      end
    end

    if (g > 0) begin : drv
      function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        v = W'($urandom);
        case ($urandom_range(0, 7))
          0: v = '1;
          1: begin v = '1; v = v >> 1; end
          2: begin v = '1; v = ~(v >> 1); end
          3: v = '0;
          default: ;
        endcase
        return v;
      endfunction

      initial begin
        int n;
        iv = 1'b0; ci = 1'b0; sb = 1'b0; orr = 1'b0; a = '0; b = '0;
        wait (sweep_go);
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          a  = pick();
          b  = pick();
          ci = 1'($urandom);
          sb = 1'($urandom);
          iv = 1'b1;
          @(posedge clk);
          #1 iv = 1'b0;
          n = 0;
          while (!ov && n < 100) begin
            @(posedge clk);
            #1 n++;
          end
          chk($sformatf("cfg%0d latency", g), 64'(n), 64'(W / D));
          repeat ($urandom_range(0, 2)) @(negedge clk);
          @(negedge clk);
          orr = 1'b1;
          @(posedge clk);
          #1 orr = 1'b0;
        end
        @(negedge clk);
        chk($sformatf("cfg%0d delivered", g), 64'(delivered), 64'd1000);
        sweep_done++;
      end
    end
  end

  // Issue one op on cfg[0]; returns edges from acceptance to out_valid visible.
  task automatic op0(input logic [31:0] aa, input logic [31:0] bb, input logic ci,
                     input logic sb, output int lat);
    @(negedge clk);
    cfg[0].a  = aa;
    cfg[0].b  = bb;
    cfg[0].ci = ci;
    cfg[0].sb = sb;
    cfg[0].iv = 1'b1;
    chk("in_ready before accept", {63'd0, cfg[0].ir}, 64'd1);
    @(posedge clk);
    #1 cfg[0].iv = 1'b0;
    lat = 0;
    while (!cfg[0].ov && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic release0(input int hold);
    repeat (hold) @(negedge clk);
    @(negedge clk);
    cfg[0].orr = 1'b1;
    @(posedge clk);
    #1 cfg[0].orr = 1'b0;
    chk("out_valid drops after handshake", {63'd0, cfg[0].ov}, 64'd0);
    chk("in_ready back in IDLE", {63'd0, cfg[0].ir}, 64'd1);
  endtask

  initial begin
    int lat;
    int n;
    logic [31:0] held;
    cfg[0].iv = 1'b0; cfg[0].orr = 1'b0; cfg[0].ci = 1'b0; cfg[0].sb = 1'b0;
    cfg[0].a = '0; cfg[0].b = '0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("reset in_ready", {63'd0, cfg[0].ir}, 64'd1);
    chk("reset out_valid", {63'd0, cfg[0].ov}, 64'd0);
    chk("reset sum", 64'(cfg[0].s), 64'd0);
    chk("reset cout", {63'd0, cfg[0].co}, 64'd0);
    chk("reset ovf", {63'd0, cfg[0].of}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Unsigned wrap; out_valid in cycle 5 counting the acceptance cycle as 0
    op0(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
    chk("wrap out_valid cycle", 64'(lat + 1), 64'd5);
    chk("wrap sum", 64'(cfg[0].s), 64'h0);
    chk("wrap cout", {63'd0, cfg[0].co}, 64'd1);
    chk("wrap ovf", {63'd0, cfg[0].of}, 64'd0);
    release0(0);

    // Signed overflow
    op0(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
`ifdef DIGIT_SERIAL_ADDER_SAT_EN
    chk("ovf sum", 64'(cfg[0].s), 64'h7FFF_FFFF);
`else
    chk("ovf sum", 64'(cfg[0].s), 64'h8000_0000);
`endif
    chk("ovf cout", {63'd0, cfg[0].co}, 64'd0);
    chk("ovf flag", {63'd0, cfg[0].of}, 64'd1);
    release0(1);

    // Subtract with borrow, cin ignored
    op0(32'd5, 32'd7, 1'b1, 1'b1, lat);
    chk("sub borrow sum", 64'(cfg[0].s), 64'hFFFF_FFFE);
    chk("sub borrow cout", {63'd0, cfg[0].co}, 64'd0);
    chk("sub borrow ovf", {63'd0, cfg[0].of}, 64'd0);
    release0(0);
    op0(32'd7, 32'd5, 1'b1, 1'b1, lat);
    chk("sub no-borrow sum", 64'(cfg[0].s), 64'd2);
    chk("sub no-borrow cout", {63'd0, cfg[0].co}, 64'd1);
    release0(0);

    // Backpressure: result frozen while inputs churn
    op0(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat);
    held = cfg[0].s;
    chk("bp sum", 64'(held), 64'h2345_6789);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cfg[0].a  = $urandom;
      cfg[0].b  = $urandom;
      cfg[0].ci = 1'($urandom);
      cfg[0].sb = 1'($urandom);
      cfg[0].iv = 1'b1;
      @(posedge clk);
      #1;
      chk("bp sum stable", 64'(cfg[0].s), 64'h2345_6789);
      chk("bp cout stable", {63'd0, cfg[0].co}, 64'd0);
      chk("bp ovf stable", {63'd0, cfg[0].of}, 64'd0);
      chk("bp in_ready low", {63'd0, cfg[0].ir}, 64'd0);
      chk("bp out_valid held", {63'd0, cfg[0].ov}, 64'd1);
    end
    @(negedge clk);
    cfg[0].orr = 1'b1;
    @(posedge clk);
    #1 cfg[0].orr = 1'b0;
    chk("bp release out_valid", {63'd0, cfg[0].ov}, 64'd0);
    chk("bp release in_ready", {63'd0, cfg[0].ir}, 64'd1);
    @(posedge clk);
    #1 cfg[0].iv = 1'b0;
    chk("bp new op accepted", {63'd0, cfg[0].ir}, 64'd0);
    lat = 0;
    while (!cfg[0].ov && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("bp new op out_valid cycle", 64'(lat + 1), 64'd5);
    release0(0);

    // Reset in the middle of RUN
    @(negedge clk);
    cfg[0].a = 32'h11; cfg[0].b = 32'h22; cfg[0].sb = 1'b0; cfg[0].iv = 1'b1;
    @(posedge clk);
    #1 cfg[0].iv = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun reset in_ready", {63'd0, cfg[0].ir}, 64'd1);
    chk("midrun reset out_valid", {63'd0, cfg[0].ov}, 64'd0);
    chk("midrun reset sum", 64'(cfg[0].s), 64'd0);
    chk("midrun reset cout", {63'd0, cfg[0].co}, 64'd0);
    chk("midrun reset ovf", {63'd0, cfg[0].of}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1 chk("no result after abort", {63'd0, cfg[0].ov}, 64'd0);
    end
    op0(32'd3, 32'd4, 1'b0, 1'b0, lat);
    chk("post-reset out_valid cycle", 64'(lat + 1), 64'd5);
    chk("post-reset sum", 64'(cfg[0].s), 64'd7);
    release0(0);

    // Random ops on the default configuration
    for (int i = 0; i < 200; i++) begin
      op0($urandom, $urandom, 1'($urandom), 1'($urandom), lat);
      chk("rand latency", 64'(lat), 64'd4);
      release0($urandom_range(0, 2));
    end

    // DIGIT=1 and DIGIT=WIDTH sweeps run concurrently
    sweep_go = 1'b1;
    n = 0;
    while (sweep_done < 2 && n < 60000) begin
      @(posedge clk);
      n++;
    end
    if (sweep_done < 2) begin
      checks++;
      errors++;
      $display("FAIL sweep timeout: %0d of 2 configurations finished", sweep_done);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
Parametrised multi-cycle add/subtract unit. Processes a WIDTH-bit operand pair DIGIT bits per cycle, least significant digit first, using one DIGIT-wide ripple adder.
Successor to the fixed 8-bit combinational parallel adder. It trades latency for area on wide datapaths and adds subtract mode, signed overflow and valid/ready handshakes on input and output.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT
DIGIT, 8, bits processed per cycle; 1 <= DIGIT <= WIDTH
(derived localparam NDIG = WIDTH/DIGIT; counter width = clog2(NDIG), minimum 1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands present
in_ready  out  1  block can accept operands
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in (add mode only)
sub  in  1  1 = A - B, 0 = A + B + cin
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
sum  out  WIDTH  result
cout  out  1  carry out of MSB (sub mode: 1 = no borrow)
ovf  out  1  signed two's-complement overflow

Behaviour:
- Reset (async assert, sync deassert by the system):
  - state=IDLE
  - in_ready=1, out_valid=0, sum=0, cout=0, ovf=0
  - digit counter=0
  - operand shift registers cleared
- FSM IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch a, b^{WIDTH{sub}} and carry = sub ? 1 : cin. Go to RUN, counter=0.
- FSM RUN:
  - in_ready=0.
  - Each cycle, add low digit of A, low digit of B' and carry.
  - Shift the result digit into sum from the MSB side, shift A and B' right by DIGIT, register the carry, counter+1.
  - After NDIG cycles go to DONE.
  - ovf = carry into MSB xor carry out of MSB, captured on the final digit.
- FSM DONE:
  - out_valid=1; sum/cout/ovf stable while out_valid && !out_ready.
  - On out_ready go to IDLE; out_valid drops next cycle.
- Latency: acceptance edge at cycle 0 gives out_valid=1 from cycle NDIG+1.
  - Throughput: one operation per NDIG+2 cycles.
- Inputs a/b/cin/sub are sampled only at acceptance; changes afterwards are ignored.
- in_valid during RUN/DONE is not accepted; upstream must hold it.
- Wrap-around: sum is modulo 2^WIDTH; cout reports the wrap.
- NDIG=1 (DIGIT=WIDTH): RUN lasts exactly one cycle.
- Reset mid-RUN or mid-DONE aborts the operation immediately, returns all outputs to reset values, and produces no partial result.

Optional Feature:
DIGIT_SERIAL_ADDER_SAT_EN:
- Defined: when ovf=1, sum is replaced by the signed saturation value.
  - 0x7FF..F if the MSB of operand A was 0, else 0x800..0.
  - ovf and cout are still reported unchanged.
- Undefined: sum is always the wrapped result; no saturation logic is present.

Decomposition:
- Shared package adder_pkg:
  - state enum {IDLE, RUN, DONE}
  - WIDTH/DIGIT default constants
  - a clog2 helper function
- One natural sub-module: digit_adder.
  - Combinational DIGIT-bit ripple adder built from fullAdder cells.
  - Ports a, b, cin, sum, cout, plus c_msb_in (carry into top bit) for overflow detection.

Test Plan:
(WIDTH=32, DIGIT=8 unless stated)
1. Unsigned wrap: a=0xFFFFFFFF, b=1, cin=0, sub=0 -> sum=0x00000000, cout=1, ovf=0; out_valid rises exactly 5 cycles after acceptance.
2. Signed overflow: a=0x7FFFFFFF, b=1, add -> sum=0x80000000, cout=0, ovf=1; with DIGIT_SERIAL_ADDER_SAT_EN -> sum=0x7FFFFFFF, ovf=1.
3. Subtract with borrow: a=5, b=7, sub=1, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0. Then a=7, b=5 -> sum=2, cout=1.
4. Backpressure: hold out_ready=0 for 3 cycles after out_valid; change a/b/in_valid meanwhile -> sum/cout/ovf constant, in_ready=0. Release -> IDLE next cycle; new operands accepted.
5. Reset mid-RUN: assert rst_n=0 asynchronously at cycle 2 of RUN -> outputs at reset values immediately, no out_valid. After release, 3+4 gives sum=7 with normal latency.
6. Parameter sweep: DIGIT=1 (32 RUN cycles) and DIGIT=WIDTH=16 (1 RUN cycle), 1000 random operands each -> sum/cout/ovf match a reference model.
